// File: rtl/i3c_sdr_pkg.sv
// Shared constants, state encoding and parity helper for the I3C SDR header decoder.
package i3c_sdr_pkg;

    localparam logic [6:0] BCAST_ADDR = 7'h7E;
    localparam int         HDR_BITS   = 8;
    localparam int         CCC_BITS   = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_NACK,
        ST_CCC,
        ST_DONE
    } state_e;

    // The T-bit of a CCC byte makes the 9-bit total odd.
    function automatic logic odd_parity_bit(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/i3c_sdr_shift_rx.sv
// 9-bit MSB-first receive shift register with a 4-bit bit counter; clear wins over shift.
module i3c_sdr_shift_rx
    import i3c_sdr_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    input  logic                shift_i,
    input  logic                bit_i,
    output logic [CCC_BITS-1:0] data_o,
    output logic [3:0]          cnt_o
);

    logic [CCC_BITS-1:0] data_q;
    logic [3:0]          cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            data_q <= {data_q[CCC_BITS-2:0], bit_i};
            cnt_q  <= cnt_q + 4'd1;
        end
    end

    assign data_o = data_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/i3c_sdr_hdr_decoder.sv
// I3C SDR header decoder: address/RW match, open-drain ACK, CCC capture.
// Optional CCC T-bit check enabled by defining I3C_CCC_PARITY_CHECK_EN.
module i3c_sdr_hdr_decoder #(
    parameter int         NUM_TGT    = 1,
    parameter logic [6:0] BCAST_ADDR = i3c_sdr_pkg::BCAST_ADDR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 scl_rising,
    input  logic                 scl_falling,
    input  logic                 sda_in,
    input  logic                 start_detected,
    input  logic                 stop_detected,
    input  logic [7*NUM_TGT-1:0] dyn_addr,
    input  logic [NUM_TGT-1:0]   dyn_addr_vld,
    output logic                 sda_oe,
    output logic                 sda_out,
    output logic                 hdr_private,
    output logic                 hdr_rw,
    output logic [1:0]           hdr_tgt,
    output logic                 ccc_valid,
    output logic [7:0]           ccc_code,
    output logic                 parity_err,
    output logic                 busy
);
    import i3c_sdr_pkg::*;

    state_e              state_q;
    logic                sda_oe_q, ack_ccc_q, fall_seen_q;
    logic                hdr_private_q, hdr_rw_q, ccc_valid_q;
    logic [1:0]          hdr_tgt_q;
    logic [7:0]          ccc_code_q;
    logic [CCC_BITS-1:0] sh_data;
    logic [3:0]          sh_cnt;
    logic                go_idle, go_addr, hdr_done, ccc_done, ack_release, nack_leave;
    logic                shift_en, shift_clr, slot_hit, parity_ok;
    logic [1:0]          slot_idx;
    logic [6:0]          hdr_addr;
    logic [7:0]          ccc_byte;

    assign go_idle     = stop_detected;
    assign go_addr     = start_detected & ~stop_detected;
    // Bytes resolve one clock after their last SCL rising, once the shifter holds them whole.
    assign hdr_done    = (state_q == ST_ADDR) && (sh_cnt == 4'(HDR_BITS)) && !go_idle && !go_addr;
    assign ccc_done    = (state_q == ST_CCC) && (sh_cnt == 4'(CCC_BITS)) && !go_idle && !go_addr;
    assign ack_release = (state_q == ST_ACK) && scl_falling && sda_oe_q && !go_idle && !go_addr;
    assign nack_leave  = (state_q == ST_NACK) && scl_falling && fall_seen_q && !go_idle && !go_addr;
    assign shift_en    = scl_rising &&
                         (((state_q == ST_ADDR) && (sh_cnt < 4'(HDR_BITS))) ||
                          ((state_q == ST_CCC)  && (sh_cnt < 4'(CCC_BITS))));
    assign shift_clr   = go_idle | go_addr | hdr_done | ccc_done | ack_release | nack_leave;
    assign hdr_addr    = sh_data[7:1];
    assign ccc_byte    = sh_data[8:1];

    i3c_sdr_shift_rx u_shift_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (shift_clr),
        .shift_i (shift_en),
        .bit_i   (sda_in),
        .data_o  (sh_data),
        .cnt_o   (sh_cnt)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        slot_hit = 1'b0;
        slot_idx = 2'd0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (dyn_addr_vld[i] && (dyn_addr[7*i +: 7] == hdr_addr)) begin
                slot_hit = 1'b1;
                slot_idx = 2'(i);
            end
        end
    end

`ifdef I3C_CCC_PARITY_CHECK_EN
    logic parity_err_q;
    assign parity_ok  = (sh_data[0] == odd_parity_bit(ccc_byte));
    assign parity_err = parity_err_q;
`else
    assign parity_ok  = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sda_oe_q      <= 1'b0;
            ack_ccc_q     <= 1'b0;
            fall_seen_q   <= 1'b0;
            hdr_private_q <= 1'b0;
            hdr_rw_q      <= 1'b0;
            hdr_tgt_q     <= 2'd0;
            ccc_valid_q   <= 1'b0;
            ccc_code_q    <= 8'd0;
`ifdef I3C_CCC_PARITY_CHECK_EN
            parity_err_q  <= 1'b0;
`endif
        end else begin
            hdr_private_q <= 1'b0;
            ccc_valid_q   <= 1'b0;
`ifdef I3C_CCC_PARITY_CHECK_EN
            parity_err_q  <= 1'b0;
`endif
            if (go_idle) begin
                state_q  <= ST_IDLE;
                sda_oe_q <= 1'b0;
            end else if (go_addr) begin
                state_q  <= ST_ADDR;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (hdr_done) begin
                            fall_seen_q <= 1'b0;
                            if (hdr_addr == BCAST_ADDR) begin
                                state_q   <= sh_data[0] ? ST_NACK : ST_ACK;
                                ack_ccc_q <= 1'b1;
                            end else if (slot_hit) begin
                                state_q   <= ST_ACK;
                                ack_ccc_q <= 1'b0;
                                hdr_rw_q  <= sh_data[0];
                                hdr_tgt_q <= slot_idx;
                            end else begin
                                state_q <= ST_NACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (scl_falling) begin
                            sda_oe_q <= ~sda_oe_q;
                            if (sda_oe_q) begin
                                state_q       <= ack_ccc_q ? ST_CCC : ST_DONE;
                                hdr_private_q <= ~ack_ccc_q;
                            end
                        end
                    end
                    ST_NACK: begin
                        if (scl_falling) begin
                            fall_seen_q <= 1'b1;
                            if (fall_seen_q) state_q <= ST_DONE;
                        end
                    end
                    ST_CCC: begin
                        if (ccc_done) begin
                            state_q <= ST_DONE;
                            if (parity_ok) begin
                                ccc_valid_q <= 1'b1;
                                ccc_code_q  <= ccc_byte;
                            end
`ifdef I3C_CCC_PARITY_CHECK_EN
                            else begin
                                parity_err_q <= 1'b1;
                            end
`endif
                        end
                    end
                    ST_IDLE, ST_DONE: begin
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign sda_oe      = sda_oe_q;
    assign sda_out     = 1'b0;
    assign hdr_private = hdr_private_q;
    assign hdr_rw      = hdr_rw_q;
    assign hdr_tgt     = hdr_tgt_q;
    assign ccc_valid   = ccc_valid_q;
    assign ccc_code    = ccc_code_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i3c_sdr_hdr_decoder.sv
// Self-checking bench for i3c_sdr_hdr_decoder: directed I3C headers plus randomized traffic
// scored against a transaction-level model; honours I3C_CCC_PARITY_CHECK_EN.
module tb_i3c_sdr_hdr_decoder;

    localparam int NT     = 4;
    localparam int K_NACK = 0;
    localparam int K_CCC  = 1;
    localparam int K_PRIV = 2;

    logic            clk = 1'b0;
    logic            rst_n, scl_rising, scl_falling, sda_in, start_detected, stop_detected;
    logic [7*NT-1:0] dyn_addr;
    logic [NT-1:0]   dyn_addr_vld;
    logic            sda_oe, sda_out, hdr_private, hdr_rw, ccc_valid, parity_err, busy;
    logic [1:0]      hdr_tgt;
    logic [7:0]      ccc_code;

    int         n_checks = 0;
    int         n_fails  = 0;
    int         priv_cnt, ccc_cnt, perr_cnt;
    logic       last_rw;
    logic [1:0] last_tgt;
    logic [7:0] exp_ccc;
    logic [6:0] slot_addr [NT];
    logic       slot_vld  [NT];

    i3c_sdr_hdr_decoder #(.NUM_TGT(NT), .BCAST_ADDR(7'h7E)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .scl_rising     (scl_rising),
        .scl_falling    (scl_falling),
        .sda_in         (sda_in),
        .start_detected (start_detected),
        .stop_detected  (stop_detected),
        .dyn_addr       (dyn_addr),
        .dyn_addr_vld   (dyn_addr_vld),
        .sda_oe         (sda_oe),
        .sda_out        (sda_out),
        .hdr_private    (hdr_private),
        .hdr_rw         (hdr_rw),
        .hdr_tgt        (hdr_tgt),
        .ccc_valid      (ccc_valid),
        .ccc_code       (ccc_code),
        .parity_err     (parity_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor: counts one-cycle pulses, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (hdr_private) begin
            priv_cnt = priv_cnt + 1;
            last_rw  = hdr_rw;
            last_tgt = hdr_tgt;
        end
        if (ccc_valid)  ccc_cnt  = ccc_cnt + 1;
        if (parity_err) perr_cnt = perr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        priv_cnt = 0;
        ccc_cnt  = 0;
        perr_cnt = 0;
    endtask

    task automatic apply_slots();
        for (int i = 0; i < NT; i++) begin
            dyn_addr[7*i +: 7] = slot_addr[i];
            dyn_addr_vld[i]    = slot_vld[i];
        end
    endtask

    task automatic strobe_start();
        tick(); start_detected = 1'b1;
        tick(); start_detected = 1'b0;
    endtask

    task automatic strobe_stop();
        tick(); stop_detected = 1'b1;
        tick(); stop_detected = 1'b0;
    endtask

    // One SCL period; oe_hi is SDA drive while SCL is high.
    task automatic send_clock(input logic b, output logic oe_hi);
        tick(); sda_in = b; scl_rising = 1'b1;
        tick(); scl_rising = 1'b0;
        tick();
        tick(); oe_hi = sda_oe; scl_falling = 1'b1;
        tick(); scl_falling = 1'b0;
        tick();
    endtask

    task automatic send_bits(input logic [8:0] v, input int n);
        logic d;
        for (int i = n - 1; i >= 0; i--) send_clock(v[i], d);
    endtask

    // Transaction-level model of how the target answers a header.
    function automatic int model_kind(input logic [6:0] a, input logic rw, output logic [1:0] tgt);
        tgt = 2'd0;
        if (a == 7'h7E) return rw ? K_NACK : K_CCC;
        for (int i = 0; i < NT; i++)
            if (slot_vld[i] && slot_addr[i] == a) begin
                tgt = 2'(i);
                return K_PRIV;
            end
        return K_NACK;
    endfunction

    task automatic run_txn(input string tag, input logic skip_start, input logic [6:0] a,
                           input logic rw, input logic [7:0] ccc, input logic t, input logic do_stop);
        int         kind;
        logic [1:0] tgt;
        logic       oe9, good, exp_valid;
        kind = model_kind(a, rw, tgt);
        if (!skip_start) strobe_start();
        clear_mon();
        send_bits({1'b0, a, rw}, 8);
        send_clock(1'b1, oe9);
        check({tag, ".ack9"}, oe9, kind != K_NACK);
        check({tag, ".oe_rel"}, sda_oe, 0);
        if (kind == K_CCC) begin
            send_bits({ccc, t}, 9);
            tick(); tick();
            good = ($countones({ccc, t}) % 2) == 1;
`ifdef I3C_CCC_PARITY_CHECK_EN
            exp_valid = good;
`else
            exp_valid = 1'b1;
`endif
            if (exp_valid) exp_ccc = ccc;
            check({tag, ".ccc_valid"}, ccc_cnt, exp_valid);
            check({tag, ".parity_err"}, perr_cnt, !exp_valid);
            check({tag, ".ccc_code"}, ccc_code, exp_ccc);
        end else begin
            check({tag, ".ccc_none"}, ccc_cnt + perr_cnt, 0);
        end
        check({tag, ".priv"}, priv_cnt, kind == K_PRIV);
        if (kind == K_PRIV) check({tag, ".rw_tgt"}, {last_rw, last_tgt}, {rw, tgt});
        check({tag, ".busy_done"}, busy, 1);
        if (do_stop) begin
            strobe_stop();
            check({tag, ".idle"}, {busy, sda_oe}, 0);
        end
    endtask

    initial begin
        logic [6:0] ra;
        int         pick;
        rst_n = 1'b0; scl_rising = 1'b0; scl_falling = 1'b0; sda_in = 1'b1;
        start_detected = 1'b0; stop_detected = 1'b0; exp_ccc = 8'h00;
        for (int i = 0; i < NT; i++) begin
            slot_addr[i] = 7'h00;
            slot_vld[i]  = 1'b0;
        end
        apply_slots();
        clear_mon();
        tick(); tick();
        check("reset.outputs",
              {sda_oe, sda_out, hdr_private, hdr_rw, hdr_tgt, ccc_valid, ccc_code, parity_err, busy}, 0);
        rst_n = 1'b1;
        tick();

        // Broadcast write followed by CCC 0x06 with a correct T-bit.
        strobe_start();
        check("t1.busy", busy, 1);
        run_txn("t1", 1'b1, 7'h7E, 1'b0, 8'h06, 1'b1, 1'b1);

        // Private read to slot 1; slot 3 holds the same address and must lose.
        slot_addr[0] = 7'h21; slot_vld[0] = 1'b1;
        slot_addr[1] = 7'h12; slot_vld[1] = 1'b1;
        slot_addr[2] = 7'h12; slot_vld[2] = 1'b0;
        slot_addr[3] = 7'h12; slot_vld[3] = 1'b1;
        apply_slots();
        run_txn("t2", 1'b0, 7'h12, 1'b1, 8'h00, 1'b0, 1'b1);
        run_txn("t3", 1'b0, 7'h33, 1'b0, 8'h00, 1'b0, 1'b1);
        run_txn("t4a", 1'b0, 7'h7E, 1'b1, 8'h00, 1'b0, 1'b0);
        run_txn("t4b", 1'b0, 7'h7E, 1'b0, 8'h07, 1'b0, 1'b1);

        // Sr after four address bits, then an Sr coinciding with an SCL rising edge.
        strobe_start();
        clear_mon();
        send_bits(9'h00F, 4);
        tick(); start_detected = 1'b1; scl_rising = 1'b1; sda_in = 1'b1;
        tick(); start_detected = 1'b0; scl_rising = 1'b0;
        check("t5.no_pulse", priv_cnt + ccc_cnt, 0);
        run_txn("t5", 1'b1, 7'h12, 1'b0, 8'h00, 1'b0, 1'b1);

        // CCC 0x06 with wrong T-bit.
        run_txn("t6", 1'b0, 7'h7E, 1'b0, 8'h06, 1'b0, 1'b1);

        // STOP while ACK is driven.
        strobe_start();
        send_bits({1'b0, 7'h7E, 1'b0}, 8);
        check("t7.ack_drv", sda_oe, 1);
        strobe_stop();
        check("t7.stop_rel", {sda_oe, busy}, 0);

        // Asynchronous reset while ACK is driven.
        strobe_start();
        send_bits({1'b0, 7'h12, 1'b1}, 8);
        check("t8.ack_drv", sda_oe, 1);
        #2 rst_n = 1'b0;
        #1 check("t8.async_rel", {sda_oe, busy, hdr_rw, hdr_tgt, ccc_code}, 0);
        exp_ccc = 8'h00;
        tick(); rst_n = 1'b1;
        tick();

        // Randomized headers against the model.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NT; i++) begin
                slot_addr[i] = 7'($urandom_range(0, 127));
                slot_vld[i]  = 1'($urandom);
            end
            if ($urandom_range(0, 3) == 0) slot_addr[1] = slot_addr[2];
            apply_slots();
            pick = int'($urandom_range(0, 9));
            if (pick < 5)      ra = slot_addr[$urandom_range(0, NT - 1)];
            else if (pick < 7) ra = 7'h7E;
            else               ra = 7'($urandom_range(0, 127));
            run_txn($sformatf("rnd%0d", n), 1'b0, ra, 1'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom));
        end
        strobe_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
